// File: rtl/mux_rr_stream_if.sv
// Handshake bundle for mux_rr_stream: NCH producer streams in, one consumer stream out.
// The slave modport is the mux's view; master is the producer/consumer side.
interface mux_rr_stream_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
);
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic [SELW-1:0]      out_ch;
  logic                 out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/mux_rr_stream.sv
// N:1 stream multiplexer, fixed-select or round-robin arbitration,
// with a single registered output stage and valid/ready backpressure.
module mux_rr_stream #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  mux_rr_stream_if.slave bus
);

  logic [WIDTH-1:0] data_p1;
  logic [SELW-1:0]  ch_p1;
  logic             vld_p1;
  logic [SELW-1:0]  ptr;

  logic             load_en;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt;
  logic [WIDTH-1:0] gnt_data;

  assign load_en = !vld_p1 || bus.out_ready;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    if (bus.mode) begin
      // channels at or above ptr take priority, then the search wraps to the low ones
      for (int k = 0; k < NCH; k++) begin
        if (!gnt_vld && bus.in_valid[k] && (SELW'(k) >= ptr)) begin
          gnt_vld = 1'b1;
          gnt     = SELW'(k);
        end
      end
      for (int k = 0; k < NCH; k++) begin
        if (!gnt_vld && bus.in_valid[k]) begin
          gnt_vld = 1'b1;
          gnt     = SELW'(k);
        end
      end
    end else begin
      // a sel value at or beyond NCH matches no channel and so grants nothing
      for (int k = 0; k < NCH; k++) begin
        if ((SELW'(k) == bus.sel) && bus.in_valid[k]) begin
          gnt_vld = 1'b1;
          gnt     = SELW'(k);
        end
      end
    end
  end

  always_comb begin
    gnt_data     = '0;
    bus.in_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      if (SELW'(k) == gnt) begin
        gnt_data        = bus.in_data[k*WIDTH +: WIDTH];
        bus.in_ready[k] = !rst && load_en && gnt_vld;
      end
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p1 <= '0;
      ch_p1   <= '0;
      vld_p1  <= 1'b0;
      ptr     <= '0;
    end else if (load_en) begin
      if (gnt_vld) begin
        data_p1 <= gnt_data;
        ch_p1   <= gnt;
        vld_p1  <= 1'b1;
        if (bus.mode) begin
          ptr <= (gnt == SELW'(NCH-1)) ? '0 : gnt + 1'b1;
        end
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_p1;
  assign bus.out_ch    = ch_p1;
  assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: directed scenarios plus a random soak, all checked
// against a cycle-level reference model and a per-channel sequence scoreboard.
module tb_mux_rr_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_rr_stream_if #(.WIDTH(8), .NCH(4)) bus4 ();
  mux_rr_stream_if #(.WIDTH(8), .NCH(3)) bus3 ();

  mux_rr_stream #(.WIDTH(8), .NCH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  mux_rr_stream #(.WIDTH(8), .NCH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  int n_vec = 0;
  int n_err = 0;

  // stimulus for the 4-channel instance
  logic       mode_d;
  logic [1:0] sel_d;
  logic [3:0] valid_d;
  logic [7:0] data_d [4];
  logic       oready_d;

  // reference model state
  logic       m_vld;
  logic [7:0] m_data;
  int         m_ch;
  int         m_ptr;
  bit         m_acc;
  int         m_g;

  // scoreboard
  bit sb_on = 1'b0;
  int seq [4];
  int osq [4];

  logic [7:0] held_data;
  logic [1:0] held_ch;
  int         exp_ch [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_data = '0;
    m_ch   = 0;
    m_ptr  = 0;
  endtask

  // Called at a falling edge: drive, check against the model, advance across one rising edge.
  task automatic step();
    bit         ld;
    bit         gv;
    int         g;
    logic [3:0] er;
    bus4.mode      = mode_d;
    bus4.sel       = sel_d;
    bus4.in_valid  = valid_d;
    bus4.out_ready = oready_d;
    for (int k = 0; k < 4; k++) bus4.in_data[k*8 +: 8] = data_d[k];
    #1;
    ld = !m_vld || oready_d;
    gv = 1'b0;
    g  = 0;
    if (mode_d) begin
      for (int i = 0; i < 4; i++) begin
        int k;
        k = (m_ptr + i) % 4;
        if (!gv && valid_d[k]) begin
          gv = 1'b1;
          g  = k;
        end
      end
    end else if (valid_d[sel_d]) begin
      gv = 1'b1;
      g  = int'(sel_d);
    end
    er = (ld && gv) ? 4'(1 << g) : 4'b0000;
    chk("in_ready",  32'(bus4.in_ready),  32'(er));
    chk("out_valid", 32'(bus4.out_valid), 32'(m_vld));
    chk("out_data",  32'(bus4.out_data),  32'(m_data));
    chk("out_ch",    32'(bus4.out_ch),    32'(m_ch));
    if (sb_on && bus4.out_valid && oready_d) begin
      chk("sb_seq", 32'(bus4.out_data), 32'({bus4.out_ch, 6'(osq[bus4.out_ch])}));
      osq[bus4.out_ch]++;
    end
    @(posedge clk);
    m_acc = ld && gv;
    m_g   = g;
    if (ld) begin
      if (gv) begin
        m_vld  = 1'b1;
        m_data = data_d[g];
        m_ch   = g;
        if (mode_d) m_ptr = (g + 1) % 4;
      end else begin
        m_vld = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    mode_d   = 1'b1;
    sel_d    = 2'd0;
    valid_d  = 4'hF;
    oready_d = 1'b1;
    bus4.mode = 1'b1;  bus4.sel = '0; bus4.in_valid = 4'hF; bus4.out_ready = 1'b1;
    bus4.in_data = 32'hA5060F05;
    bus3.mode = 1'b1;  bus3.sel = '0; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
    bus3.in_data = 24'h323130;

    // reset with every channel valid
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus4.out_data),  32'd0);
    chk("rst_out_ch",    32'(bus4.out_ch),    32'd0);
    chk("rst_in_ready",  32'(bus4.in_ready),  32'd0);
    chk("rst_in_ready3", 32'(bus3.in_ready),  32'd0);
    chk("rst_out_valid3", 32'(bus3.out_valid), 32'd0);
    bus4.in_valid = 4'h0;
    bus3.in_valid = 3'b000;
    rst = 1'b0;

    // three channels: wrap from ptr=2 and out-of-range fixed select
    bus3.in_valid = 3'b010;
    @(negedge clk);
    chk("n3_first_ch", 32'(bus3.out_ch), 32'd1);
    bus3.in_valid = 3'b001;
    @(negedge clk);
    chk("n3_wrap_ch",    32'(bus3.out_ch),   32'd0);
    chk("n3_wrap_data",  32'(bus3.out_data), 32'h30);
    bus3.in_valid = 3'b111;
    @(negedge clk);
    chk("n3_ptr1_ch", 32'(bus3.out_ch), 32'd1);
    bus3.mode = 1'b0;
    bus3.sel  = 2'd3;
    #1;
    chk("n3_sel3_ready", 32'(bus3.in_ready), 32'd0);
    @(negedge clk);
    chk("n3_sel3_valid", 32'(bus3.out_valid), 32'd0);
    chk("n3_sel3_hold",  32'(bus3.out_ch),    32'd1);
    bus3.in_valid = 3'b000;

    // fixed select
    data_d[0] = 8'h05; data_d[1] = 8'h0F; data_d[2] = 8'h06; data_d[3] = 8'hA5;
    mode_d = 1'b0; valid_d = 4'hF; oready_d = 1'b1;
    sel_d = 2'd2; step();
    chk("fix_sel2_data", 32'(bus4.out_data), 32'h06);
    chk("fix_sel2_ch",   32'(bus4.out_ch),   32'd2);
    sel_d = 2'd3; step();
    chk("fix_sel3_data", 32'(bus4.out_data), 32'hA5);
    chk("fix_sel3_ch",   32'(bus4.out_ch),   32'd3);
    sel_d = 2'd1; step();
    chk("fix_sel1_data", 32'(bus4.out_data), 32'h0F);
    chk("fix_sel1_ch",   32'(bus4.out_ch),   32'd1);

    // round-robin, all valid then ch1/ch3 only
    mode_d = 1'b1;
    exp_ch = '{0, 1, 2, 3, 0};
    foreach (exp_ch[i]) begin
      step();
      chk("rr_all_ch", 32'(bus4.out_ch), 32'(exp_ch[i]));
    end
    valid_d = 4'b1010;
    exp_ch = '{1, 3, 1, 3};
    foreach (exp_ch[i]) begin
      step();
      chk("rr_13_ch", 32'(bus4.out_ch), 32'(exp_ch[i]));
    end

    // backpressure for three cycles, then release
    valid_d   = 4'hF;
    oready_d  = 1'b0;
    held_data = bus4.out_data;
    held_ch   = bus4.out_ch;
    repeat (3) begin
      step();
      chk("bp_hold_data", 32'(bus4.out_data), 32'(held_data));
      chk("bp_hold_ch",   32'(bus4.out_ch),   32'(held_ch));
    end
    oready_d = 1'b1;
    step();
    chk("bp_release_ch", 32'(bus4.out_ch), 32'd0);

    // asynchronous reset pulse between clock edges
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("arst_in_ready",  32'(bus4.in_ready),  32'd0);
    bus4.in_valid = 4'h0;
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    valid_d = 4'hF;
    step();
    chk("arst_restart_ch",    32'(bus4.out_ch),    32'd0);
    chk("arst_restart_valid", 32'(bus4.out_valid), 32'd1);

    // drain, then random soak with per-channel sequence numbers
    valid_d = 4'h0;
    step();
    for (int k = 0; k < 4; k++) begin
      seq[k] = 0;
      osq[k] = 0;
    end
    sb_on = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      mode_d   = ($urandom_range(0, 7) != 0);
      sel_d    = 2'($urandom_range(0, 3));
      valid_d  = 4'($urandom);
      oready_d = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) data_d[k] = {2'(k), 6'(seq[k])};
      step();
      if (m_acc) seq[m_g]++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
